// File: rtl/mult16_seq_pkg.sv
// Shared types and helpers for the sequential 16x16 tile multiplier.
// The product is built from sixteen 4x4 digit tiles, one tile per cycle.
package mult16_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int TILE_W    = 4;
  localparam int NUM_TILES = 16;

  // Digit-index sum i+j for tile k (i = k[1:0], j = k[3:2]).
  function automatic logic [2:0] digit_sum(input logic [3:0] k);
    digit_sum = {1'b0, k[1:0]} + {1'b0, k[3:2]};
  endfunction

  // Bit position of tile k's partial product: 4*(i+j).
  function automatic logic [4:0] tile_shift(input logic [3:0] k);
    tile_shift = {digit_sum(k), 2'b00};
  endfunction

endpackage

// File: rtl/mult16_seq_ctrl_tile.sv
// Combinational 4x4 -> 8-bit unsigned multiplier.
// A single instance is time-shared by the controller across all tiles.
module mult4x4_tile (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);

  assign p = {4'b0000, a} * {4'b0000, b};

endmodule

// File: rtl/mult16_seq_ctrl.sv
// Sequential 16x16 unsigned multiplier: accepts an operand pair, accumulates
// one 4x4 tile per cycle for 16 cycles, then holds the product until taken.
module mult16_seq_ctrl
  import mult16_seq_pkg::*;
#(
  parameter int APPROX_LEVEL = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_p,
  output logic        busy
);

  state_t      state_r;
  state_t      state_s;
  logic [3:0]  k_r;
  logic [15:0] a_r;
  logic [15:0] b_r;
  logic [31:0] acc_r;

  logic [15:0] a_shift_s;
  logic [15:0] b_shift_s;
  logic [7:0]  tile_p_s;
  logic        skip_s;
  logic [31:0] term_s;

  // Select the current a digit (i = k[1:0]) and b digit (j = k[3:2]).
  assign a_shift_s = a_r >> {k_r[1:0], 2'b00};
  assign b_shift_s = b_r >> {k_r[3:2], 2'b00};

  mult4x4_tile u_tile (
    .a (a_shift_s[TILE_W-1:0]),
    .b (b_shift_s[TILE_W-1:0]),
    .p (tile_p_s)
  );

  // Low-significance tiles are dropped when approximation is enabled.
  assign skip_s = ({29'd0, digit_sum(k_r)} < 32'(APPROX_LEVEL));
  assign term_s = skip_s ? 32'd0 : ({24'd0, tile_p_s} << tile_shift(k_r));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (in_valid) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (k_r == 4'(NUM_TILES - 1)) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Operand capture, tile counter and accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r   <= 16'd0;
      b_r   <= 16'd0;
      acc_r <= 32'd0;
      k_r   <= 4'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            a_r   <= in_a;
            b_r   <= in_b;
            acc_r <= 32'd0;
            k_r   <= 4'd0;
          end
        end
        ST_RUN: begin
          acc_r <= acc_r + term_s;
          k_r   <= k_r + 4'd1;
        end
        ST_DONE: begin
          acc_r <= acc_r;
        end
        default: begin
          acc_r <= 32'd0;
          k_r   <= 4'd0;
        end
      endcase
    end
  end

  assign in_ready  = (state_r == ST_IDLE);
  assign out_valid = (state_r == ST_DONE);
  assign busy      = (state_r != ST_IDLE);
  assign out_p     = acc_r;

endmodule

// File: tb/tb_mult16_seq_ctrl.sv
// Directed and randomized checks for mult16_seq_ctrl; a second instance with
// APPROX_LEVEL=2 runs in lockstep to check the approximate-tile behaviour.
module tb_mult16_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        in_ready,   in_ready_2;
  logic        out_valid,  out_valid_2;
  logic [31:0] out_p,      out_p_2;
  logic        busy,       busy_2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mult16_seq_ctrl #(.APPROX_LEVEL(0)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_p(out_p), .busy(busy)
  );

  mult16_seq_ctrl #(.APPROX_LEVEL(2)) dut_2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_2),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid_2), .out_ready(out_ready),
    .out_p(out_p_2), .busy(busy_2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One full transaction: offer, count latency, optionally hold off, handshake.
  task automatic do_op(input logic [15:0] a, input logic [15:0] b,
                       input logic [31:0] exp, input bit use_2,
                       input logic [31:0] exp_2, input int hold, input bit toggle);
    int lat;
    bit run_bad;
    @(negedge clk);
    chk("idle_ready", {31'd0, in_ready}, 32'd1);
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    run_bad = 1'b0;
    while (!out_valid && lat < 40) begin
      if (in_ready || !busy) run_bad = 1'b1;
      if (toggle) begin
        in_valid  = ~in_valid;
        out_ready = ~out_ready;
        in_a = 16'($urandom);
        in_b = 16'($urandom);
      end
      @(negedge clk);
      lat++;
    end
    out_ready = 1'b0;
    chk("latency", 32'(lat), 32'd16);
    chk("run_flags", {31'd0, run_bad}, 32'd0);
    chk("product", out_p, exp);
    chk("done_busy", {31'd0, busy}, 32'd1);
    if (use_2) chk("approx_product", out_p_2, exp_2);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_p", out_p, exp);
      chk("hold_valid", {31'd0, out_valid}, 32'd1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b0;
    chk("post_hs_valid", {31'd0, out_valid}, 32'd0);
    chk("post_hs_ready", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    bit ghost;
    logic [15:0] ra, rb;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_a = 16'd0;
    in_b = 16'd0;
    #1;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_busy",  {31'd0, busy}, 32'd0);
    chk("rst_p",     out_p, 32'd0);
    #11 rst_n = 1'b1;

    do_op(16'h0003, 16'h0005, 32'h0000000F, 1'b1, 32'h00000000, 0, 1'b0);
    do_op(16'hFFFF, 16'hFFFF, 32'hFFFE0001, 1'b0, 32'h0, 5, 1'b0);
    do_op(16'h000F, 16'h000F, 32'h000000E1, 1'b1, 32'h00000000, 0, 1'b0);
    do_op(16'h0011, 16'h0011, 32'h00000121, 1'b1, 32'h00000100, 1, 1'b0);
    do_op(16'h1234, 16'h5678, 32'h06260060, 1'b0, 32'h0, 0, 1'b1);
    do_op(16'h00FF, 16'h0100, 32'h0000FF00, 1'b0, 32'h0, 0, 1'b0);

    // Abandon an operation part-way through RUN (k = 7).
    @(negedge clk);
    in_a = 16'h1234;
    in_b = 16'h5678;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrun_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("midrun_rst_ready", {31'd0, in_ready}, 32'd1);
    chk("midrun_rst_busy",  {31'd0, busy}, 32'd0);
    chk("midrun_rst_p",     out_p, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ghost = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (out_valid) ghost = 1'b1;
    end
    chk("no_ghost_valid", {31'd0, ghost}, 32'd0);
    do_op(16'h0002, 16'h0007, 32'h0000000E, 1'b0, 32'h0, 0, 1'b0);

    for (int n = 0; n < 300; n++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      do_op(ra, rb, {16'd0, ra} * {16'd0, rb}, 1'b0, 32'h0,
            int'($urandom_range(0, 3)), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
